instruction_fetch: RTL

IF stage of the five-stage MIPS pipeline, directly upstream of the decode stage. Holds the program counter, a word-addressed instruction memory loaded by the Debug Unit, next-PC selection (sequential, jump, jr/jalr, taken branch) and the IF/ID pipeline register feeding the decode stage's instruction and PC inputs. Handles stall, redirect flush and halt freeze.

---
 rtl/instruction_fetch_pkg.sv | 21 ++
 rtl/instruction_fetch_memory.sv | 25 ++
 rtl/instruction_fetch.sv | 114 +++++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared constants and encodings for the IF stage: NOP word, PC reset value,
// next-PC select codes and the fetch FSM states.
package instruction_fetch_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam logic [31:0] PC_RESET = 32'h0000_0000;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_JUMP,
        SEL_JR,
        SEL_BRANCH,
        SEL_HOLD
    } next_pc_sel_e;

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } if_state_e;

endpackage

// File: rtl/instruction_fetch_memory.sv
// Word-addressed instruction store: synchronous write from the Debug Unit,
// asynchronous read for fetch. Contents are deliberately not reset.
module instruction_memory #(
    parameter int ADDR_SIZE = 8,
    parameter int DATA_SIZE = 32
) (
    input  logic                 i_clock,
    input  logic                 i_write_enable,
    input  logic [ADDR_SIZE-1:0] i_write_addr,
    input  logic [DATA_SIZE-1:0] i_write_data,
    input  logic [ADDR_SIZE-1:0] i_read_addr,
    output logic [DATA_SIZE-1:0] o_read_data
);

    logic [DATA_SIZE-1:0] r_mem [2**ADDR_SIZE];

    always_ff @(posedge i_clock) begin
        if (i_write_enable) begin
            r_mem[i_write_addr] <= i_write_data;
        end
    end

    assign o_read_data = r_mem[i_read_addr];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: program counter, next-PC selection, IF/ID register and halt FSM.
//   state     | meaning
//   ST_RUN    | fetching; PC and IF/ID advance whenever the pipeline is enabled
//   ST_HALTED | halt seen in ID; PC frozen, IF/ID holds NOP until reset
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int PC_SIZE        = 32,
    parameter int INST_SIZE      = 32,
    parameter int IMEM_ADDR_SIZE = 8
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_pipeline_enable,
    input  logic                      i_stall,
    input  logic                      i_jump,
    input  logic [PC_SIZE-1:0]        i_jump_addr,
    input  logic                      i_jr_jalr,
    input  logic [PC_SIZE-1:0]        i_jr_addr,
    input  logic                      i_branch_taken,
    input  logic [PC_SIZE-1:0]        i_branch_addr,
    input  logic                      i_halt,
    input  logic                      i_imem_write_enable,
    input  logic [IMEM_ADDR_SIZE-1:0] i_imem_write_addr,
    input  logic [INST_SIZE-1:0]      i_imem_write_data,
    output logic [INST_SIZE-1:0]      o_inst,
    output logic [PC_SIZE-1:0]        o_pc,
    output logic [PC_SIZE-1:0]        o_pc_current,
    output logic                      o_halted
);

    logic [PC_SIZE-1:0]   r_pc;
    logic [PC_SIZE-1:0]   r_if_pc;
    logic [INST_SIZE-1:0] r_inst;
    logic                 r_halted;
    if_state_e            r_state;

    logic [PC_SIZE-1:0]   w_pc_plus1;
    logic [PC_SIZE-1:0]   w_next_pc;
    logic [INST_SIZE-1:0] w_imem_rdata;
    next_pc_sel_e         w_sel;
    logic                 w_step;

    instruction_memory #(
        .ADDR_SIZE (IMEM_ADDR_SIZE),
        .DATA_SIZE (INST_SIZE)
    ) u_imem (
        .i_clock        (i_clock),
        .i_write_enable (i_imem_write_enable),
        .i_write_addr   (i_imem_write_addr),
        .i_write_data   (i_imem_write_data),
        .i_read_addr    (r_pc[IMEM_ADDR_SIZE-1:0]),
        .o_read_data    (w_imem_rdata)
    );

    assign w_step     = i_pipeline_enable && (r_state == ST_RUN);
    assign w_pc_plus1 = r_pc + PC_SIZE'(1);

    // Stall outranks jumps because the ID instruction will be re-decoded next cycle.
    always_comb begin
        w_sel = SEL_SEQ;
        if (i_branch_taken)  w_sel = SEL_BRANCH;
        else if (i_halt)     w_sel = SEL_HOLD;
        else if (i_stall)    w_sel = SEL_HOLD;
        else if (i_jr_jalr)  w_sel = SEL_JR;
        else if (i_jump)     w_sel = SEL_JUMP;
    end

    always_comb begin
        w_next_pc = r_pc;
        case (w_sel)
            SEL_BRANCH: w_next_pc = i_branch_addr;
            SEL_JR:     w_next_pc = i_jr_addr;
            SEL_JUMP:   w_next_pc = i_jump_addr;
            SEL_SEQ:    w_next_pc = w_pc_plus1;
            default:    w_next_pc = r_pc;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_pc     <= PC_SIZE'(PC_RESET);
            r_inst   <= INST_SIZE'(NOP_INST);
            r_if_pc  <= '0;
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
        end else if (w_step) begin
            r_pc <= w_next_pc;
            if (i_branch_taken || i_halt) begin
                r_inst  <= INST_SIZE'(NOP_INST);
                r_if_pc <= '0;
            end else if (i_stall) begin
                r_inst  <= r_inst;
                r_if_pc <= r_if_pc;
            end else if (i_jr_jalr || i_jump) begin
                r_inst  <= INST_SIZE'(NOP_INST);
                r_if_pc <= '0;
            end else begin
                r_inst  <= w_imem_rdata;
                r_if_pc <= w_pc_plus1;
            end
            if (i_halt) begin
                r_state  <= ST_HALTED;
                r_halted <= 1'b1;
            end
        end
    end

    assign o_inst       = r_inst;
    assign o_pc         = r_if_pc;
    assign o_pc_current = r_pc;
    assign o_halted     = r_halted;

endmodule
